me_search_ctrl: RTL and testbench
=================================

ME_SEARCH_CTRL -- requirements
Module: me_search_ctrl

Interface
REQ-001 Parameter RANGE_X, default 16, candidates per row (1..32).
REQ-002 Parameter RANGE_Y, default 16, candidate rows (1..32).
REQ-003 Parameter SAD_LAT, default 4, fixed cycles from candidate acceptance to SAD result at comparator (1..8).
REQ-004 clk  input  1  clock; all state on rising edge.
REQ-005 reset  input  1  reset, asynchronous, active-high.
REQ-006 go  input  1  start one full-window search; sampled in IDLE only.
REQ-007 abort  input  1  terminate the current search, no result.
REQ-008 eng_ready  input  1  SAD engine accepts the offered candidate this cycle.
REQ-009 cand_valid  output  1  candidate offered to SAD engine.
REQ-010 cand_pos  output  10  candidate position {y[4:0], x[4:0]}.
REQ-011 cmp_clear  output  1  clear pulse to best-match comparator.
REQ-012 cmp_start  output  1  comparator enable, aligned with SAD result.
REQ-013 cmp_position  output  10  position tag aligned with cmp_start.
REQ-014 best_sad_in  input  16  comparator running-minimum SAD.
REQ-015 best_pos_in  input  10  comparator running-best position.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 done  output  1  one-cycle pulse, result valid.
REQ-018 result_sad  output  16  captured final minimum SAD.
REQ-019 result_pos  output  10  captured final best position.

Function
REQ-020 FSM states: IDLE, CLEAR, ISSUE, DRAIN, FINISH; all outputs registered or decoded from registered state.
REQ-021 IDLE: go=1 -> CLEAR; otherwise stay.
REQ-022 CLEAR: cmp_clear=1 for exactly this cycle; x=0, y=0 -> ISSUE.
REQ-023 ISSUE: cand_valid=1, cand_pos={y,x}; acceptance = cand_valid & eng_ready; without acceptance, cand_pos holds.
REQ-024 On acceptance: x+1; at x=RANGE_X-1, x wraps to 0 and y+1; raster order, x fastest.
REQ-025 Acceptance of {RANGE_Y-1, RANGE_X-1} -> DRAIN; cand_valid=0 from the next cycle.
REQ-026 Delay line: SAD_LAT stages of (valid, pos), shifting every cycle unconditionally; an acceptance in cycle t yields cmp_start=1, cmp_position=pos in cycle t+SAD_LAT; a non-acceptance cycle inserts a bubble (cmp_start=0).
REQ-027 DRAIN: lasts exactly SAD_LAT+1 cycles, then -> FINISH.
REQ-028 Leaving DRAIN: result_sad<=best_sad_in, result_pos<=best_pos_in.
REQ-029 FINISH: done=1 for one cycle -> IDLE; result registers hold until the next FINISH.
REQ-030 With eng_ready held 1 and N=RANGE_X*RANGE_Y, done is high in cycle N+SAD_LAT+3, counting the go-sampled cycle as 0.
REQ-031 abort in CLEAR, ISSUE, DRAIN or FINISH: next state IDLE; delay line flushed; cmp_clear=1 in the following cycle; done not asserted; result registers unchanged.
REQ-032 abort and go both high in IDLE: abort wins; stay IDLE.
REQ-033 go while busy: ignored.
REQ-034 RANGE_X=RANGE_Y=1: ISSUE lasts one accepted cycle, then DRAIN.

Reset
REQ-035 On reset: state IDLE; x, y, delay line cleared; cand_valid, cmp_clear, cmp_start, busy, done = 0; cand_pos, cmp_position, result_pos = 0; result_sad = 16'hFFFF.
REQ-036 Reset mid-search: immediate return to reset values; no done.

Verification (RANGE_X=RANGE_Y=4, SAD_LAT=4, N=16)
REQ-037 go at cycle 0, eng_ready=1 -> cmp_clear in cycle 1; cand_pos 0x000..0x003, 0x020.. in cycles 2..17; done in cycle 23.
REQ-038 Model comparator with unique minimum SAD at pos {2,1}=0x041 -> result_pos=0x041, result_sad=minimum at done.
REQ-039 eng_ready low on alternate cycles -> no position skipped or repeated; cmp_start bubbles match stalls with SAD_LAT offset; done in cycle 39.
REQ-040 abort during ISSUE after 5 acceptances -> IDLE next cycle, cmp_clear pulse, no cmp_start afterward, done never asserted, result unchanged.
REQ-041 Reset asserted mid-DRAIN -> all outputs at reset values; a new go then gives a normal done in cycle 23.
REQ-042 go and abort together in IDLE -> busy stays 0; go while busy -> no restart, done timing unchanged.

Source files
------------

// File: rtl/me_search_ctrl.sv
// Motion-estimation search controller: walks a RANGE_X x RANGE_Y candidate window in raster
// order, tags each accepted candidate through a SAD_LAT delay line, then captures the best match.
module me_search_ctrl #(
  parameter int RANGE_X = 16,
  parameter int RANGE_Y = 16,
  parameter int SAD_LAT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        go_i,
  input  logic        abort_i,
  input  logic        eng_ready_i,
  output logic        cand_valid_o,
  output logic [9:0]  cand_pos_o,
  output logic        cmp_clear_o,
  output logic        cmp_start_o,
  output logic [9:0]  cmp_position_o,
  input  logic [15:0] best_sad_in_i,
  input  logic [9:0]  best_pos_in_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [15:0] result_sad_o,
  output logic [9:0]  result_pos_o
);

  typedef enum logic [2:0] {IDLE, CLEAR, ISSUE, DRAIN, FINISH} state_t;

  localparam logic [4:0] X_LAST     = 5'(RANGE_X - 1);
  localparam logic [4:0] Y_LAST     = 5'(RANGE_Y - 1);
  localparam logic [3:0] DRAIN_LAST = 4'(SAD_LAT);

  state_t             state_q;
  logic [4:0]         x_q, y_q;
  logic               candValid_q;
  logic               cmpClear_q;
  logic [3:0]         drainCnt_q;
  logic [15:0]        resultSad_q;
  logic [9:0]         resultPos_q;
  logic [SAD_LAT-1:0] dlyVld_q;
  logic [9:0]         dlyPos_q [SAD_LAT];
  logic               accept;
  logic               lastCand;
  logic               abortHit;

  assign accept   = candValid_q & eng_ready_i;
  assign lastCand = (x_q == X_LAST) && (y_q == Y_LAST);
  assign abortHit = abort_i && (state_q != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      candValid_q <= 1'b0;
      cmpClear_q  <= 1'b0;
      drainCnt_q  <= '0;
      resultSad_q <= 16'hFFFF;
      resultPos_q <= '0;
    end else begin
      cmpClear_q <= 1'b0;
      if (abortHit) begin
        state_q     <= IDLE;
        candValid_q <= 1'b0;
        cmpClear_q  <= 1'b1;
      end else begin
        case (state_q)
          IDLE: begin
            // abort in IDLE blocks a simultaneous go
            if (go_i && !abort_i) begin
              state_q    <= CLEAR;
              cmpClear_q <= 1'b1;
            end
          end
          CLEAR: begin
            x_q         <= '0;
            y_q         <= '0;
            candValid_q <= 1'b1;
            state_q     <= ISSUE;
          end
          ISSUE: begin
            if (accept) begin
              if (lastCand) begin
                candValid_q <= 1'b0;
                drainCnt_q  <= '0;
                state_q     <= DRAIN;
              end else if (x_q == X_LAST) begin
                x_q <= '0;
                y_q <= y_q + 5'd1;
              end else begin
                x_q <= x_q + 5'd1;
              end
            end
          end
          DRAIN: begin
            if (drainCnt_q == DRAIN_LAST) begin
              resultSad_q <= best_sad_in_i;
              resultPos_q <= best_pos_in_i;
              state_q     <= FINISH;
            end else begin
              drainCnt_q <= drainCnt_q + 4'd1;
            end
          end
          FINISH:  state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // Fixed-latency tag pipe mirroring the SAD engine; a stalled cycle travels through as a bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dlyVld_q <= '0;
      for (int k = 0; k < SAD_LAT; k++) dlyPos_q[k] <= '0;
    end else begin
      dlyVld_q[0] <= accept;
      dlyPos_q[0] <= {y_q, x_q};
      for (int k = 1; k < SAD_LAT; k++) begin
        dlyVld_q[k] <= dlyVld_q[k-1];
        dlyPos_q[k] <= dlyPos_q[k-1];
      end
      if (abortHit) dlyVld_q <= '0;
    end
  end

  assign cand_valid_o   = candValid_q;
  assign cand_pos_o     = {y_q, x_q};
  assign cmp_clear_o    = cmpClear_q;
  assign cmp_start_o    = dlyVld_q[SAD_LAT-1];
  assign cmp_position_o = dlyPos_q[SAD_LAT-1];
  assign busy_o         = (state_q != IDLE);
  assign done_o         = (state_q == FINISH);
  assign result_sad_o   = resultSad_q;
  assign result_pos_o   = resultPos_q;

endmodule

// File: tb/tb_me_search_ctrl.sv
// Bench for me_search_ctrl on a 4x4 window with SAD_LAT=4, including a behavioural
// best-match comparator and a raster-order reference of the whole search.
module tb_me_search_ctrl;

  localparam int RX  = 4;
  localparam int RY  = 4;
  localparam int LAT = 4;
  localparam int N   = RX * RY;

  logic        clk = 1'b0;
  logic        reset;
  logic        go, abort, engReady;
  logic        candValid, cmpClear, cmpStart, busy, done;
  logic [9:0]  candPos, cmpPosition, bestPos, resultPos;
  logic [15:0] bestSad, resultSad;

  logic [15:0] sadTab [N];
  int          errors = 0;
  int          checks = 0;

  typedef struct {
    int          cyc;
    logic [9:0]  pos;
  } acc_t;

  typedef struct {
    bit         go, abort, ready;
    bit         expBusy, expValid;
    logic [9:0] expPos;
    bit         expClear, expStart, expDone;
  } vec_t;

  me_search_ctrl #(.RANGE_X(RX), .RANGE_Y(RY), .SAD_LAT(LAT)) dut (
    .clk           (clk),
    .reset         (reset),
    .go_i          (go),
    .abort_i       (abort),
    .eng_ready_i   (engReady),
    .cand_valid_o  (candValid),
    .cand_pos_o    (candPos),
    .cmp_clear_o   (cmpClear),
    .cmp_start_o   (cmpStart),
    .cmp_position_o(cmpPosition),
    .best_sad_in_i (bestSad),
    .best_pos_in_i (bestPos),
    .busy_o        (busy),
    .done_o        (done),
    .result_sad_o  (resultSad),
    .result_pos_o  (resultPos)
  );

  always #5 clk = ~clk;

  // Best-match comparator the controller steers; looks up the SAD of each tagged position.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      bestSad <= 16'hFFFF;
      bestPos <= '0;
    end else if (cmpClear) begin
      bestSad <= 16'hFFFF;
      bestPos <= '0;
    end else if (cmpStart && sadTab[{cmpPosition[6:5], cmpPosition[1:0]}] < bestSad) begin
      bestSad <= sadTab[{cmpPosition[6:5], cmpPosition[1:0]}];
      bestPos <= cmpPosition;
    end
  end

  function automatic logic [9:0] rasterPos(input int n);
    return {5'(n / RX), 5'(n % RX)};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, " busy"},       32'(busy),        32'd0);
    checkOutput({tag, " cand_valid"}, 32'(candValid),   32'd0);
    checkOutput({tag, " cand_pos"},   32'(candPos),     32'd0);
    checkOutput({tag, " cmp_clear"},  32'(cmpClear),    32'd0);
    checkOutput({tag, " cmp_start"},  32'(cmpStart),    32'd0);
    checkOutput({tag, " cmp_pos"},    32'(cmpPosition), 32'd0);
    checkOutput({tag, " done"},       32'(done),        32'd0);
    checkOutput({tag, " result_sad"}, 32'(resultSad),   32'hFFFF);
    checkOutput({tag, " result_pos"}, 32'(resultPos),   32'd0);
  endtask

  // One full search from go to the IDLE cycle after done; the model only knows raster order,
  // the acceptance rule and the documented latencies.
  task automatic applyStimulus(input int mode, input int minIdx, input bit noisyGo, input int fixedDone);
    acc_t        accQ[$];
    int          accepted = 0;
    int          lastAcc  = -1;
    int          obsDone  = -1;
    int          minI     = 0;
    logic [15:0] minSad;
    logic [9:0]  minPos;
    bit          expValid, expStart, rdy;
    int          endCyc;

    for (int i = 0; i < N; i++) sadTab[i] = 16'(200 + $urandom_range(0, 3000));
    sadTab[minIdx] = 16'($urandom_range(0, 199));
    for (int i = 1; i < N; i++) if (sadTab[i] < sadTab[minI]) minI = i;
    minSad = sadTab[minI];
    minPos = rasterPos(minI);

    for (int c = 0; c <= 400; c++) begin
      expValid = (c >= 2) && (accepted < N);
      endCyc   = (lastAcc >= 0) ? lastAcc + LAT + 2 : -1;
      if (c > 0) begin
        if (endCyc >= 0 && c == endCyc + 1) begin
          checkOutput("idle busy", 32'(busy), 32'd0);
          checkOutput("idle done", 32'(done), 32'd0);
          checkOutput("held result_sad", 32'(resultSad), 32'(minSad));
          checkOutput("held result_pos", 32'(resultPos), 32'(minPos));
          checkOutput("done cycle", 32'(obsDone), 32'(fixedDone >= 0 ? fixedDone : endCyc));
          break;
        end
        checkOutput("busy", 32'(busy), 32'd1);
        checkOutput("cand_valid", 32'(candValid), 32'(expValid));
        if (expValid) checkOutput("cand_pos", 32'(candPos), 32'(rasterPos(accepted)));
        checkOutput("cmp_clear", 32'(cmpClear), 32'(c == 1));
        expStart = (accQ.size() > 0) && (accQ[0].cyc + LAT == c);
        checkOutput("cmp_start", 32'(cmpStart), 32'(expStart));
        if (expStart) begin
          checkOutput("cmp_position", 32'(cmpPosition), 32'(accQ[0].pos));
          void'(accQ.pop_front());
        end
        checkOutput("done", 32'(done), 32'(c == endCyc));
        if (done && obsDone < 0) obsDone = c;
        if (c == endCyc) begin
          checkOutput("result_sad", 32'(resultSad), 32'(minSad));
          checkOutput("result_pos", 32'(resultPos), 32'(minPos));
        end
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (c % 2) == 1;
        default: rdy = ($urandom_range(0, 3) != 0);
      endcase
      go       = (c == 0) || (noisyGo && $urandom_range(0, 3) == 0);
      abort    = 1'b0;
      engReady = rdy;
      if (expValid && rdy) begin
        accQ.push_back('{cyc: c, pos: rasterPos(accepted)});
        accepted++;
        if (accepted == N) lastAcc = c;
      end
      @(posedge clk); #1;
      if (c == 400) checkOutput("search timeout", 32'd1, 32'd0);
    end
    go = 1'b0;
    engReady = 1'b0;
  endtask

  initial begin
    vec_t vecs[$];

    reset = 1'b1; go = 1'b0; abort = 1'b0; engReady = 1'b0;
    for (int i = 0; i < N; i++) sadTab[i] = 16'hFFFF;
    repeat (2) @(posedge clk);
    #1;
    checkResetValues("reset");
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;

    // go+abort in IDLE, stalled issue, go while busy, then abort after two acceptances.
    vecs.push_back('{1, 1, 0, 0, 0, 10'h000, 0, 0, 0});
    vecs.push_back('{1, 0, 0, 0, 0, 10'h000, 0, 0, 0});
    vecs.push_back('{0, 0, 0, 1, 0, 10'h000, 1, 0, 0});
    vecs.push_back('{0, 0, 0, 1, 1, 10'h000, 0, 0, 0});
    vecs.push_back('{0, 0, 1, 1, 1, 10'h000, 0, 0, 0});
    vecs.push_back('{1, 0, 1, 1, 1, 10'h001, 0, 0, 0});
    vecs.push_back('{0, 0, 0, 1, 1, 10'h002, 0, 0, 0});
    vecs.push_back('{0, 1, 1, 1, 1, 10'h002, 0, 0, 0});
    vecs.push_back('{0, 0, 0, 0, 0, 10'h000, 1, 0, 0});
    vecs.push_back('{0, 0, 0, 0, 0, 10'h000, 0, 0, 0});
    vecs.push_back('{0, 0, 0, 0, 0, 10'h000, 0, 0, 0});
    foreach (vecs[k]) begin
      checkOutput($sformatf("vec%0d busy", k),      32'(busy),      32'(vecs[k].expBusy));
      checkOutput($sformatf("vec%0d cand_valid", k), 32'(candValid), 32'(vecs[k].expValid));
      if (vecs[k].expValid)
        checkOutput($sformatf("vec%0d cand_pos", k), 32'(candPos), 32'(vecs[k].expPos));
      checkOutput($sformatf("vec%0d cmp_clear", k), 32'(cmpClear),  32'(vecs[k].expClear));
      checkOutput($sformatf("vec%0d cmp_start", k), 32'(cmpStart),  32'(vecs[k].expStart));
      checkOutput($sformatf("vec%0d done", k),      32'(done),      32'(vecs[k].expDone));
      go       = vecs[k].go;
      abort    = vecs[k].abort;
      engReady = vecs[k].ready;
      @(posedge clk); #1;
    end
    go = 1'b0; abort = 1'b0; engReady = 1'b0;
    checkOutput("abort result_sad", 32'(resultSad), 32'hFFFF);
    checkOutput("abort result_pos", 32'(resultPos), 32'd0);

    applyStimulus(0, 9, 1'b0, 23);
    applyStimulus(1, 9, 1'b1, 39);
    for (int r = 0; r < 4; r++) applyStimulus(2, $urandom_range(0, N - 1), 1'b1, -1);

    // Reset landing in the middle of DRAIN, then a clean search afterwards.
    go = 1'b1; engReady = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    repeat (19) begin
      @(posedge clk); #1;
    end
    checkOutput("pre-reset busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    checkResetValues("mid-drain reset");
    @(negedge clk) reset = 1'b0;
    engReady = 1'b0;
    @(posedge clk); #1;
    applyStimulus(0, 9, 1'b0, 23);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
